// File: rtl/branch_resolve_calcpc.sv
// Execute-stage branch/jump resolver: computes the actual direction and target,
// flags fetch mispredicts with a one-cycle flush pulse, and emits predictor writeback.

module brc_compare (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  code,
  output logic        taken
);
  always_comb begin
    taken = 1'b0;
    case (code)
      3'b001:  taken = (a == b);
      3'b010:  taken = (a != b);
      3'b011:  taken = ($signed(a) <  $signed(b));
      3'b100:  taken = ($signed(a) >= $signed(b));
      3'b101:  taken = (a <  b);
      3'b110:  taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end
endmodule

// Saturating up-counter; sticks at all-ones instead of wrapping.
module brc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module branch_resolve_calcpc #(
  parameter int PC_W  = 13,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       branch_numberE,
  input  logic [PC_W-1:0]  pcEj,
  input  logic [31:0]      reg_data1Ej,
  input  logic [31:0]      reg_data2Ej,
  input  logic [PC_W-1:0]  immEj,
  input  logic [1:0]       jump_codeEj,
  input  logic [2:0]       branch_codeEj,
  input  logic [1:0]       stateEj,
  output logic             fail_predict,
  output logic [PC_W-1:0]  pc_redirect,
  output logic [31:0]      link_data,
  output logic             pred_wr_en,
  output logic [1:0]       pred_wr_idx,
  output logic [1:0]       pred_wr_state,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  logic            fail_predict_q, fail_predict_d;
  logic [PC_W-1:0] pc_redirect_q, pc_redirect_d;
  logic [31:0]     link_data_q, link_data_d;
  logic            pred_wr_en_q, pred_wr_en_d;
  logic [1:0]      pred_wr_idx_q, pred_wr_idx_d;
  logic [1:0]      pred_wr_state_q, pred_wr_state_d;

  logic            is_jal, is_jalr, is_jump, is_br, valid;
  logic            br_taken, taken, mispredict;
  logic [PC_W-1:0] pc_plus4, pc_tgt, jalr_sum, target;
  logic [1:0]      state_up, state_dn;

  brc_compare u_cmp (
    .a     (reg_data1Ej),
    .b     (reg_data2Ej),
    .code  (branch_codeEj),
    .taken (br_taken)
  );

  always_comb begin
    is_jal   = (jump_codeEj == 2'b01);
    is_jalr  = (jump_codeEj == 2'b10);
    is_jump  = is_jal | is_jalr;
    is_br    = (branch_codeEj != 3'b000) && (branch_codeEj != 3'b111);
    // While the flush pulse is out, the execute inputs are wrong-path.
    valid    = (is_jump | is_br) & ~fail_predict_q;
    taken    = is_jump | br_taken;

    pc_plus4 = pcEj + PC_W'(4);
    pc_tgt   = pcEj + immEj;
    jalr_sum = reg_data1Ej[PC_W-1:0] + immEj;
    target   = is_jalr ? {jalr_sum[PC_W-1:1], 1'b0} : pc_tgt;

    // Fetch never predicts a JALR target, so it always redirects.
    mispredict = is_jalr | (taken != stateEj[1]);

    state_up = (stateEj == 2'b11) ? 2'b11 : stateEj + 2'd1;
    state_dn = (stateEj == 2'b00) ? 2'b00 : stateEj - 2'd1;
  end

  always_comb begin
    fail_predict_d  = 1'b0;
    pred_wr_en_d    = 1'b0;
    pc_redirect_d   = pc_redirect_q;
    link_data_d     = link_data_q;
    pred_wr_idx_d   = pred_wr_idx_q;
    pred_wr_state_d = pred_wr_state_q;
    if (valid) begin
      fail_predict_d  = mispredict;
      pred_wr_en_d    = 1'b1;
      pc_redirect_d   = taken ? target : pc_plus4;
      pred_wr_idx_d   = branch_numberE;
      pred_wr_state_d = taken ? state_up : state_dn;
      if (is_jump) link_data_d = {{(32-PC_W){1'b0}}, pc_plus4};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fail_predict_q  <= 1'b0;
      pc_redirect_q   <= '0;
      link_data_q     <= '0;
      pred_wr_en_q    <= 1'b0;
      pred_wr_idx_q   <= '0;
      pred_wr_state_q <= '0;
    end else begin
      fail_predict_q  <= fail_predict_d;
      pc_redirect_q   <= pc_redirect_d;
      link_data_q     <= link_data_d;
      pred_wr_en_q    <= pred_wr_en_d;
      pred_wr_idx_q   <= pred_wr_idx_d;
      pred_wr_state_q <= pred_wr_state_d;
    end
  end

  brc_sat_cnt #(.W(CNT_W)) u_br_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (valid),
    .cnt (branch_count)
  );

  brc_sat_cnt #(.W(CNT_W)) u_mp_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (fail_predict_d),
    .cnt (mispredict_count)
  );

  assign fail_predict  = fail_predict_q;
  assign pc_redirect   = pc_redirect_q;
  assign link_data     = link_data_q;
  assign pred_wr_en    = pred_wr_en_q;
  assign pred_wr_idx   = pred_wr_idx_q;
  assign pred_wr_state = pred_wr_state_q;
endmodule

// File: tb/tb_branch_resolve_calcpc.sv
// Bench for branch_resolve_calcpc: directed vector table, saturation sequence on a
// narrow-counter instance, then random ops against a behavioural model.

module tb_branch_resolve_calcpc;
  localparam int PC_W = 13;
  localparam int PCM  = 1 << PC_W;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  bn;
  logic [12:0] pc, imm;
  logic [31:0] r1, r2;
  logic [1:0]  jc, st;
  logic [2:0]  bc;

  logic        fail, wren, s_fail, s_wren;
  logic [12:0] redir, s_redir;
  logic [31:0] link, s_link;
  logic [1:0]  widx, wst, s_widx, s_wst;
  logic [15:0] bcnt, mcnt;
  logic [3:0]  s_bcnt, s_mcnt;

  always #5 CLK = ~CLK;

  branch_resolve_calcpc #(.PC_W(13), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .branch_numberE(bn), .pcEj(pc), .reg_data1Ej(r1),
    .reg_data2Ej(r2), .immEj(imm), .jump_codeEj(jc), .branch_codeEj(bc), .stateEj(st),
    .fail_predict(fail), .pc_redirect(redir), .link_data(link), .pred_wr_en(wren),
    .pred_wr_idx(widx), .pred_wr_state(wst), .branch_count(bcnt), .mispredict_count(mcnt)
  );

  branch_resolve_calcpc #(.PC_W(13), .CNT_W(4)) dut_s (
    .CLK(CLK), .RST(RST), .branch_numberE(bn), .pcEj(pc), .reg_data1Ej(r1),
    .reg_data2Ej(r2), .immEj(imm), .jump_codeEj(jc), .branch_codeEj(bc), .stateEj(st),
    .fail_predict(s_fail), .pc_redirect(s_redir), .link_data(s_link), .pred_wr_en(s_wren),
    .pred_wr_idx(s_widx), .pred_wr_state(s_wst), .branch_count(s_bcnt), .mispredict_count(s_mcnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  bn;
    logic [12:0] pc;
    logic [31:0] r1, r2;
    logic [12:0] imm;
    logic [1:0]  jc;
    logic [2:0]  bc;
    logic [1:0]  st;
    logic        e_fail;
    logic [12:0] e_redir;
    logic [31:0] e_link;
    logic        e_wren;
    logic [1:0]  e_idx, e_state;
    logic [15:0] e_bc, e_mc;
  } vec_t;

  function automatic vec_t mk(input logic rst_i, input logic [1:0] bn_i, input logic [12:0] pc_i,
                              input logic [31:0] r1_i, input logic [31:0] r2_i, input logic [12:0] imm_i,
                              input logic [1:0] jc_i, input logic [2:0] bc_i, input logic [1:0] st_i,
                              input logic ef, input logic [12:0] er, input logic [31:0] el,
                              input logic ew, input logic [1:0] ei, input logic [1:0] es,
                              input logic [15:0] ebc, input logic [15:0] emc);
    vec_t v;
    v.rst = rst_i; v.bn = bn_i; v.pc = pc_i; v.r1 = r1_i; v.r2 = r2_i; v.imm = imm_i;
    v.jc = jc_i; v.bc = bc_i; v.st = st_i; v.e_fail = ef; v.e_redir = er; v.e_link = el;
    v.e_wren = ew; v.e_idx = ei; v.e_state = es; v.e_bc = ebc; v.e_mc = emc;
    return v;
  endfunction

  // Behavioural model state
  logic        m_fail, m_wren;
  logic [12:0] m_redir;
  logic [31:0] m_link;
  logic [1:0]  m_idx, m_state;
  int          n_br, n_mp;

  task automatic model_step();
    bit vj, vb, tk, mis;
    int fall, tgt, s;
    if (RST) begin
      m_fail = 0; m_wren = 0; m_redir = 0; m_link = 0; m_idx = 0; m_state = 0;
      n_br = 0; n_mp = 0;
    end else begin
      vj = (jc == 2'd1) || (jc == 2'd2);
      vb = (bc >= 3'd1) && (bc <= 3'd6);
      if ((vj || vb) && !m_fail) begin
        if (vj) tk = 1;
        else begin
          case (bc)
            3'd1: tk = (r1 == r2);
            3'd2: tk = (r1 != r2);
            3'd3: tk = (int'(r1) <  int'(r2));
            3'd4: tk = (int'(r1) >= int'(r2));
            3'd5: tk = (r1 <  r2);
            default: tk = (r1 >= r2);
          endcase
        end
        fall = (int'(pc) + 4) % PCM;
        if (jc == 2'd2) tgt = ((int'(r1 & 32'(PCM - 1)) + int'(imm)) % PCM) & ~1;
        else            tgt = (int'(pc) + int'(imm)) % PCM;
        mis = (jc == 2'd2) || (tk != st[1]);
        s = int'(st);
        m_fail  = mis;
        m_wren  = 1;
        m_redir = 13'(tk ? tgt : fall);
        if (vj) m_link = 32'(fall);
        m_idx   = bn;
        m_state = 2'(tk ? (s == 3 ? 3 : s + 1) : (s == 0 ? 0 : s - 1));
        n_br++;
        if (mis) n_mp++;
      end else begin
        m_fail = 0;
        m_wren = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    RST = 1; bn = 0; pc = 0; imm = 0; r1 = 0; r2 = 0; jc = 0; bc = 0; st = 0;
    //        rst bn pc       r1            r2  imm     jc bc st  fail redir    link     wen idx sta bc mc
    tbl.push_back(mk(1, 1, 13'h100, 32'd5, 32'd5, 13'h020, 0, 1, 2, 0, 13'h000, 32'h000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 13'h100, 32'd5, 32'd5, 13'h020, 0, 1, 2, 0, 13'h000, 32'h000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 13'h000, 32'd0, 32'd0, 13'h000, 0, 0, 0, 0, 13'h000, 32'h000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 13'h100, 32'd5, 32'd5, 13'h020, 0, 1, 2, 0, 13'h120, 32'h000, 1, 1, 3, 1, 0));
    tbl.push_back(mk(0, 2, 13'h040, 32'hFFFFFFFF, 32'd1, 13'h010, 0, 3, 1, 1, 13'h050, 32'h000, 1, 2, 2, 2, 1));
    tbl.push_back(mk(0, 3, 13'h040, 32'hFFFFFFFF, 32'd1, 13'h010, 0, 5, 1, 0, 13'h050, 32'h000, 0, 0, 0, 2, 1));
    tbl.push_back(mk(0, 3, 13'h040, 32'hFFFFFFFF, 32'd1, 13'h010, 0, 5, 1, 0, 13'h044, 32'h000, 1, 3, 0, 3, 1));
    tbl.push_back(mk(0, 0, 13'h200, 32'h123, 32'd0, 13'h004, 2, 0, 3, 1, 13'h126, 32'h204, 1, 0, 3, 4, 2));
    tbl.push_back(mk(0, 1, 13'h300, 32'd1, 32'd2, 13'h008, 0, 2, 0, 0, 13'h126, 32'h204, 0, 0, 0, 4, 2));
    tbl.push_back(mk(0, 2, 13'h080, 32'd1, 32'd2, 13'h040, 0, 4, 0, 0, 13'h084, 32'h204, 1, 2, 0, 5, 2));
    tbl.push_back(mk(0, 0, 13'h155, 32'd9, 32'd3, 13'h0AA, 3, 7, 3, 0, 13'h084, 32'h204, 0, 0, 0, 5, 2));
    tbl.push_back(mk(0, 3, 13'h1FFC, 32'd7, 32'd7, 13'h010, 0, 2, 0, 0, 13'h000, 32'h204, 1, 3, 0, 6, 2));
    tbl.push_back(mk(0, 1, 13'h1FFC, 32'd1, 32'd2, 13'h008, 1, 1, 0, 1, 13'h004, 32'h000, 1, 1, 1, 7, 3));
    tbl.push_back(mk(0, 0, 13'h000, 32'd0, 32'd0, 13'h000, 0, 0, 0, 0, 13'h004, 32'h000, 0, 0, 0, 7, 3));
    tbl.push_back(mk(0, 2, 13'h010, 32'd0, 32'd0, 13'h100, 1, 0, 2, 0, 13'h110, 32'h014, 1, 2, 3, 8, 3));

    foreach (tbl[i]) begin
      RST = tbl[i].rst; bn = tbl[i].bn; pc = tbl[i].pc; r1 = tbl[i].r1; r2 = tbl[i].r2;
      imm = tbl[i].imm; jc = tbl[i].jc; bc = tbl[i].bc; st = tbl[i].st;
      tick();
      chk($sformatf("v%0d fail_predict", i), 32'(fail), 32'(tbl[i].e_fail));
      chk($sformatf("v%0d pc_redirect", i), 32'(redir), 32'(tbl[i].e_redir));
      chk($sformatf("v%0d link_data", i), link, tbl[i].e_link);
      chk($sformatf("v%0d pred_wr_en", i), 32'(wren), 32'(tbl[i].e_wren));
      chk($sformatf("v%0d branch_count", i), 32'(bcnt), 32'(tbl[i].e_bc));
      chk($sformatf("v%0d mispredict_count", i), 32'(mcnt), 32'(tbl[i].e_mc));
      if (tbl[i].e_wren || tbl[i].rst) begin
        chk($sformatf("v%0d pred_wr_idx", i), 32'(widx), 32'(tbl[i].e_idx));
        chk($sformatf("v%0d pred_wr_state", i), 32'(wst), 32'(tbl[i].e_state));
      end
    end

    // Repeated JALR mispredicts, each followed by its flush cycle.
    for (int k = 0; k < 20; k++) begin
      RST = 0; jc = 2'd2; bc = 3'd0; st = 2'd3; pc = 13'($urandom); r1 = $urandom; imm = 13'($urandom);
      tick();
      chk($sformatf("sat%0d fail_predict", k), 32'(fail), 32'd1);
      jc = 2'd0;
      tick();
      chk($sformatf("sat%0d squash", k), 32'(fail), 32'd0);
    end
    chk("sat mispredict_count16", 32'(mcnt), 32'd23);
    chk("sat branch_count16", 32'(bcnt), 32'd28);
    chk("sat mispredict_count4", 32'(s_mcnt), 32'hF);
    chk("sat branch_count4", 32'(s_bcnt), 32'hF);

    // Random ops against the model, with occasional reset.
    RST = 1; jc = 2'd1; tick();
    for (int k = 0; k < 400; k++) begin
      RST = ($urandom_range(0, 49) == 0);
      bn = 2'($urandom); pc = 13'($urandom); imm = 13'($urandom);
      r1 = $urandom; r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      jc = 2'($urandom); bc = 3'($urandom); st = 2'($urandom);
      if ($urandom_range(0, 1) == 0) jc = 2'd0;
      tick();
      chk($sformatf("r%0d fail_predict", k), 32'(fail), 32'(m_fail));
      chk($sformatf("r%0d pc_redirect", k), 32'(redir), 32'(m_redir));
      chk($sformatf("r%0d link_data", k), link, m_link);
      chk($sformatf("r%0d pred_wr_en", k), 32'(wren), 32'(m_wren));
      if (m_wren) begin
        chk($sformatf("r%0d pred_wr_idx", k), 32'(widx), 32'(m_idx));
        chk($sformatf("r%0d pred_wr_state", k), 32'(wst), 32'(m_state));
      end
      chk($sformatf("r%0d branch_count16", k), 32'(bcnt), 32'(n_br > 65535 ? 65535 : n_br));
      chk($sformatf("r%0d mispredict_count16", k), 32'(mcnt), 32'(n_mp > 65535 ? 65535 : n_mp));
      chk($sformatf("r%0d branch_count4", k), 32'(s_bcnt), 32'(n_br > 15 ? 15 : n_br));
      chk($sformatf("r%0d mispredict_count4", k), 32'(s_mcnt), 32'(n_mp > 15 ? 15 : n_mp));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
